// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - data-memory access stage between EX/MEM and MEM/WB
//
// Issues loads and stores from the EX/MEM register to a variable-latency data
// memory over a req/ack handshake. While an access is outstanding it holds
// the upstream pipeline with stall and sends bubbles to MEM/WB. Misaligned
// addresses, simultaneous read+write and memory timeouts are squashed
// (write-back disabled) and reported on the err_* port.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid                 EX/MEM holds a valid instruction
//   mem_read, mem_write      memory controls from EX/MEM
//   control_signal_WB[1:0]   write-back controls from EX/MEM
//   ALU_result[31:0]         word address for memory ops, result otherwise
//   write_data[31:0]         store data
//   stall                    combinational hold for EX/MEM and upstream
//   out_valid                registered; MEM/WB outputs carry an instruction
//   out_control_signal_WB    registered write-back controls
//   out_ALU_result           registered ALU result / access address
//   out_MEM_read_data        registered load data (0 for non-loads)
//   dmem_req/we/addr/wdata   registered memory request
//   dmem_rdata, dmem_ack     memory response; ack is a single-cycle strobe
//   err_valid                one-cycle error pulse
//   err_code[1:0]            01 misaligned, 10 timeout, 11 read+write
//   err_addr[31:0]           offending address, held until the next error

module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  control_signal_WB,
    input  logic [31:0] ALU_result,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic        out_valid,
    output logic [1:0]  out_control_signal_WB,
    output logic [31:0] out_ALU_result,
    output logic [31:0] out_MEM_read_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
    localparam logic [1:0] ERR_RW_BOTH    = 2'b11;

    // The counter holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1. It is
    // cleared on entry to WAIT and never exceeds 254, so it cannot wrap.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  wb_hold;      // WB controls captured when the request issues

    logic        mem_op;
    logic        rw_both;
    logic        misaligned;
    logic        illegal;
    logic        legal_op;
    logic        cnt_last;

    // Instruction decode for the IDLE state.
    always_comb begin
        mem_op     = in_valid & (mem_read | mem_write);
        rw_both    = mem_read & mem_write;
        misaligned = (ALU_result[1:0] != 2'b00);
        illegal    = mem_op & (rw_both | misaligned);
        legal_op   = mem_op & ~illegal;
        cnt_last   = (wait_cnt == LAST_WAIT);
    end

    // In WAIT, stall drops in the cycle that will complete the access, either
    // by ack or by timeout, so upstream advances on the completing edge.
    // Gating with rst keeps stall low while reset is held even if EX/MEM
    // presents a memory op.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                stall = legal_op;
            end else begin
                stall = ~dmem_ack & ~cnt_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            wait_cnt              <= 8'd0;
            wb_hold               <= 2'b00;
            out_valid             <= 1'b0;
            out_control_signal_WB <= 2'b00;
            out_ALU_result        <= 32'd0;
            out_MEM_read_data     <= 32'd0;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= 32'd0;
            dmem_wdata            <= 32'd0;
            err_valid             <= 1'b0;
            err_code              <= 2'b00;
            err_addr              <= 32'd0;
        end else begin
            err_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (illegal) begin
                        // Squashed instruction still flows down the pipe so
                        // that instruction ordering is preserved.
                        out_valid             <= 1'b1;
                        out_control_signal_WB <= 2'b00;
                        out_ALU_result        <= ALU_result;
                        out_MEM_read_data     <= 32'd0;
                        err_valid             <= 1'b1;
                        err_code              <= rw_both ? ERR_RW_BOTH : ERR_MISALIGNED;
                        err_addr              <= ALU_result;
                    end else if (legal_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= ALU_result;
                        dmem_wdata <= write_data;
                        wb_hold    <= control_signal_WB;
                        wait_cnt   <= 8'd0;
                        out_valid  <= 1'b0;
                        state      <= WAIT;
                    end else begin
                        // Non-memory op (or empty slot): pass straight through.
                        // A stray dmem_ack here has no effect.
                        out_valid             <= in_valid;
                        out_control_signal_WB <= control_signal_WB;
                        out_ALU_result        <= ALU_result;
                        out_MEM_read_data     <= 32'd0;
                    end
                end

                WAIT: begin
                    if (dmem_ack) begin
                        // Ack beats a timeout in the same cycle.
                        dmem_req              <= 1'b0;
                        out_valid             <= 1'b1;
                        out_control_signal_WB <= wb_hold;
                        out_ALU_result        <= dmem_addr;
                        out_MEM_read_data     <= dmem_we ? 32'd0 : dmem_rdata;
                        state                 <= IDLE;
                    end else if (cnt_last) begin
                        dmem_req              <= 1'b0;
                        out_valid             <= 1'b1;
                        out_control_signal_WB <= 2'b00;
                        out_ALU_result        <= dmem_addr;
                        out_MEM_read_data     <= 32'd0;
                        err_valid             <= 1'b1;
                        err_code              <= ERR_TIMEOUT;
                        err_addr              <= dmem_addr;
                        state                 <= IDLE;
                    end else begin
                        // Bubble: out_valid stays 0, other out_* hold.
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage

module tb_mem_stage;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  control_signal_WB;
    logic [31:0] ALU_result;
    logic [31:0] write_data;
    logic        stall;
    logic        out_valid;
    logic [1:0]  out_control_signal_WB;
    logic [31:0] out_ALU_result;
    logic [31:0] out_MEM_read_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .mem_read              (mem_read),
        .mem_write             (mem_write),
        .control_signal_WB     (control_signal_WB),
        .ALU_result            (ALU_result),
        .write_data            (write_data),
        .stall                 (stall),
        .out_valid             (out_valid),
        .out_control_signal_WB (out_control_signal_WB),
        .out_ALU_result        (out_ALU_result),
        .out_MEM_read_data     (out_MEM_read_data),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_rdata            (dmem_rdata),
        .dmem_ack              (dmem_ack),
        .err_valid             (err_valid),
        .err_code              (err_code),
        .err_addr              (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic        rd;
        logic        wr;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_ov;
        logic [1:0]  e_wb;
        logic [31:0] e_alu;
        logic [31:0] e_rd;
        logic        e_ev;
        logic [1:0]  e_ec;
        logic [31:0] e_ea;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [1:0] wb,
                           input logic [31:0] alu, input logic [31:0] rd,
                           input logic ev, input logic [1:0] ec, input logic [31:0] ea);
        chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(ov));
        chk($sformatf("%s.out_wb", tag), 32'(out_control_signal_WB), 32'(wb));
        chk($sformatf("%s.out_alu", tag), out_ALU_result, alu);
        chk($sformatf("%s.out_rdata", tag), out_MEM_read_data, rd);
        chk($sformatf("%s.err_valid", tag), 32'(err_valid), 32'(ev));
        chk($sformatf("%s.err_code", tag), 32'(err_code), 32'(ec));
        chk($sformatf("%s.err_addr", tag), err_addr, ea);
    endtask

    // Drives one load/store and acks it in WAIT cycle ack_at (0 = never).
    // Returns the number of cycles stall was observed high. Ends just after
    // the completing edge with EX/MEM emptied.
    task automatic mem_op(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] wb,
                          input int ack_at, input logic [31:0] rdata, output int stalls);
        bit done;
        done = 1'b0;
        in_valid          = 1'b1;
        mem_read          = !wr;
        mem_write         = wr;
        control_signal_WB = wb;
        ALU_result        = addr;
        write_data        = wd;
        stalls            = 0;
        #1;
        if (stall) stalls++;
        step();
        for (int w = 1; w <= 300 && !done; w++) begin
            if (w == 1) begin
                chk($sformatf("%s.dmem_req", tag), 32'(dmem_req), 32'd1);
                chk($sformatf("%s.dmem_we", tag), 32'(dmem_we), 32'(wr));
                chk($sformatf("%s.dmem_addr", tag), dmem_addr, addr);
                if (wr) chk($sformatf("%s.dmem_wdata", tag), dmem_wdata, wd);
                chk($sformatf("%s.bubble", tag), 32'(out_valid), 32'd0);
            end
            if (w == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            if (stall) stalls++;
            done = (w == ack_at) || (w == TO);
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hBAD0_BAD0;
        end
        chk($sformatf("%s.completed", tag), 32'(done), 32'd1);
        chk($sformatf("%s.req_dropped", tag), 32'(dmem_req), 32'd0);
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int st;

        //           iv    rd    wr    wb     alu           wd            ack   rdata         stl   ov    wb     alu           rd     ev    ec     ea
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'b10, 32'h0000_1234, 32'h0, 1'b0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0, 1'b0, 2'b00, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_1234, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 2'b10, 32'h0000_1234, 32'h0, 1'b0, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0007, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b11, 32'h0000_0007, 32'h0, 1'b0, 2'b00, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0042, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 32'h0000_0042, 32'h0, 1'b1, 2'b01, 32'h42};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_0050, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 32'h0000_0050, 32'h0, 1'b1, 2'b11, 32'h50};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b01, 32'h0000_0053, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'b00, 32'h0000_0053, 32'h0, 1'b1, 2'b11, 32'h53};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0061, 32'hAAAA_AAAA, 1'b0, 32'h0,       1'b0, 1'b1, 2'b00, 32'h0000_0061, 32'h0, 1'b1, 2'b01, 32'h61};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_CAFE, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 2'b01, 32'h0000_CAFE, 32'h0, 1'b0, 2'b01, 32'h61};

        // Reset held with a legal load presented: nothing may happen.
        rst               = 1'b0;
        in_valid          = 1'b1;
        mem_read          = 1'b1;
        mem_write         = 1'b0;
        control_signal_WB = 2'b01;
        ALU_result        = 32'h40;
        write_data        = 32'h0;
        dmem_rdata        = 32'h0;
        dmem_ack          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.dmem_req", 32'(dmem_req), 32'd0);
        chk("reset.dmem_we", 32'(dmem_we), 32'd0);
        chk("reset.dmem_addr", dmem_addr, 32'd0);
        chk("reset.dmem_wdata", dmem_wdata, 32'd0);
        chk_out("reset", 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0);

        @(negedge clk);
        in_valid = 1'b0;
        mem_read = 1'b0;
        rst      = 1'b1;

        // Single-cycle IDLE behaviour from the vector table.
        for (int i = 0; i < 9; i++) begin
            in_valid          = vecs[i].iv;
            mem_read          = vecs[i].rd;
            mem_write         = vecs[i].wr;
            control_signal_WB = vecs[i].wb;
            ALU_result        = vecs[i].alu;
            write_data        = vecs[i].wd;
            dmem_ack          = vecs[i].ack;
            dmem_rdata        = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
            step();
            dmem_ack = 1'b0;
            chk($sformatf("vec%0d.dmem_req", i), 32'(dmem_req), 32'd0);
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_wb, vecs[i].e_alu,
                    vecs[i].e_rd, vecs[i].e_ev, vecs[i].e_ec, vecs[i].e_ea);
        end

        // Load acked in the third WAIT cycle.
        mem_op("load40", 1'b0, 32'h40, 32'h0, 2'b01, 3, 32'hDEAD_BEEF, st);
        chk("load40.stalls", 32'(st), 32'd3);
        chk_out("load40", 1'b1, 2'b01, 32'h40, 32'hDEAD_BEEF, 1'b0, 2'b01, 32'h61);

        // Store then load back to back, each acked in the first WAIT cycle.
        mem_op("store80", 1'b1, 32'h80, 32'hA5A5_A5A5, 2'b10, 1, 32'h7777_7777, st);
        chk("store80.stalls", 32'(st), 32'd1);
        chk_out("store80", 1'b1, 2'b10, 32'h80, 32'h0, 1'b0, 2'b01, 32'h61);
        mem_op("load84", 1'b0, 32'h84, 32'h0, 2'b01, 1, 32'h1122_3344, st);
        chk("load84.stalls", 32'(st), 32'd1);
        chk_out("load84", 1'b1, 2'b01, 32'h84, 32'h1122_3344, 1'b0, 2'b01, 32'h61);

        // Empty slot clears the read-data register ahead of the timeout case.
        ALU_result        = 32'h84;
        control_signal_WB = 2'b01;
        step();
        chk("nop.out_valid", 32'(out_valid), 32'd0);
        chk("nop.out_rdata", out_MEM_read_data, 32'd0);

        // Timeout with no ack, then one-cycle error pulse.
        mem_op("timeout", 1'b0, 32'h200, 32'h0, 2'b11, 0, 32'h0, st);
        chk("timeout.stalls", 32'(st), 32'd4);
        chk_out("timeout", 1'b1, 2'b00, 32'h200, 32'h0, 1'b1, 2'b10, 32'h200);
        ALU_result = 32'h200;
        step();
        chk("timeout.pulse_end", 32'(err_valid), 32'd0);
        chk("timeout.code_held", 32'(err_code), 32'd2);
        chk("timeout.addr_held", err_addr, 32'h200);

        // Ack in the last allowed cycle wins over the timeout.
        mem_op("lastack", 1'b0, 32'h204, 32'h0, 2'b11, TO, 32'h1357_9BDF, st);
        chk("lastack.stalls", 32'(st), 32'd4);
        chk_out("lastack", 1'b1, 2'b11, 32'h204, 32'h1357_9BDF, 1'b0, 2'b10, 32'h200);

        // Reset in the middle of WAIT takes effect without a clock edge.
        in_valid          = 1'b1;
        mem_read          = 1'b1;
        control_signal_WB = 2'b01;
        ALU_result        = 32'h100;
        #1;
        chk("midrst.stall_idle", 32'(stall), 32'd1);
        step();
        chk("midrst.req_before", 32'(dmem_req), 32'd1);
        chk("midrst.stall_wait", 32'(stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);
        chk("midrst.err_code", 32'(err_code), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        mem_read = 1'b0;
        rst      = 1'b1;
        mem_op("postrst", 1'b0, 32'h300, 32'h0, 2'b01, 2, 32'h0BAD_CAFE, st);
        chk("postrst.stalls", 32'(st), 32'd2);
        chk_out("postrst", 1'b1, 2'b01, 32'h300, 32'h0BAD_CAFE, 1'b0, 2'b00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory access stage of the pipelined datapath, between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues loads and stores to a variable-latency data memory over a req/ack handshake. While an access is outstanding it stalls upstream and emits bubbles. On completion it delivers the ALU result, the load data and the WB control bits, registered, to the MEM/WB register. Misaligned accesses, conflicting controls and memory timeouts are reported and squashed.

## Interface
- `TIMEOUT` (default 255): maximum `WAIT` cycles before an access is aborted; range 1..255.
- `clk` (input, 1): rising-edge clock.
- `rst` (input, 1): asynchronous, active-low reset.
- `in_valid` (input, 1): EX/MEM holds a valid instruction.
- `mem_read`, `mem_write` (input, 1 each): memory controls from EX/MEM.
- `control_signal_WB` (input, 2): WB controls from EX/MEM.
- `ALU_result` (input, 32): word address for memory ops, or the result for non-memory ops.
- `write_data` (input, 32): store data.
- `stall` (output, 1): combinational; holds EX/MEM and everything upstream.
- `out_valid` (output, 1): registered; the outputs below carry a real instruction.
- `out_control_signal_WB` (output, 2): registered.
- `out_ALU_result` (output, 32): registered.
- `out_MEM_read_data` (output, 32): registered.
- `dmem_req` (output, 1): registered memory request.
- `dmem_we` (output, 1): registered; 1 means store.
- `dmem_addr` (output, 32): registered.
- `dmem_wdata` (output, 32): registered.
- `dmem_rdata` (input, 32): load data; valid when `dmem_ack` is high.
- `dmem_ack` (input, 1): single-cycle completion strobe.
- `err_valid` (output, 1): registered one-cycle pulse.
- `err_code` (output, 2): 01 misaligned, 10 timeout, 11 read and write both set.
- `err_addr` (output, 32): offending address, held until the next error.

## Operation
- Definitions:
  - mem op = `in_valid & (mem_read | mem_write)`.
  - illegal = `mem_read & mem_write`, or `ALU_result[1:0] != 0`, on a mem op.
  - Illegal-code priority: 11 over 01.
- FSM states: `IDLE`, `WAIT`.
- `IDLE`, no mem op: the next edge loads `out_*` with `in_valid`, the inputs, and `out_MEM_read_data` = 0. Latency 1 cycle; `stall` = 0.
- `IDLE`, illegal mem op:
  - No request is issued; `stall` = 0.
  - The next edge loads `out_valid` = 1, `out_control_signal_WB` = 00 (write-back squashed) and `out_ALU_result` = address.
  - The same edge pulses `err_valid` with the matching code and `err_addr`.
- `IDLE`, legal mem op:
  - `stall` = 1.
  - The next edge loads `dmem_req` = 1, `dmem_we` = `mem_write`, `dmem_addr` = `ALU_result`, `dmem_wdata` = `write_data`, timeout counter = 0, `out_valid` = 0. State goes to `WAIT`.
- `WAIT`:
  - `dmem_*` stay stable; the counter increments every cycle.
  - `stall` = `!dmem_ack`.
- `WAIT`, `dmem_ack` = 1:
  - Next edge: `dmem_req` = 0, state `IDLE`, `out_valid` = 1.
  - `out_ALU_result` = `dmem_addr`; `out_control_signal_WB` = the held EX/MEM value.
  - `out_MEM_read_data` = `dmem_rdata` for a load, 0 for a store.
  - Upstream advances on this same edge.
- `WAIT`, counter reaches `TIMEOUT` without ack:
  - `stall` = 0 that cycle.
  - Next edge: `dmem_req` = 0, state `IDLE`, `out_valid` = 1, WB = 00, `err_code` = 10 pulse, `err_addr` = `dmem_addr`.
  - An ack arriving in that same cycle wins; no error is raised.
- Stray `dmem_ack` in `IDLE` is ignored.
- Counter is 8 bits and never wraps: it is cleared on entry to `WAIT`.

## Timing
- Reset low, asynchronous:
  - State `IDLE`; counter 0.
  - `dmem_req`, `dmem_we`, `out_valid`, `err_valid` = 0.
  - All data/address outputs and `err_code` = 0.
  - `stall` = 0 while in reset.
- Reset during `WAIT`: `dmem_req` drops immediately and the access is abandoned. Memory must tolerate a request withdrawn without ack.
- Load/store accepted in cycle T:
  - `dmem_req` is high from T+1.
  - If ack arrives in cycle T+k (k ≥ 1), the result is visible at T+k+1 and `stall` is high for cycles T..T+k-1.
  - Minimum penalty is 1 stall cycle.
- While `out_valid` = 0 (bubble), the other `out_*` keep their previous values.
- Back-to-back mem ops: the next op is sampled in `IDLE` the cycle after ack, with no idle gap.
- `err_valid` is high exactly one cycle per error.

## Test plan
- Reset then ALU op: `in_valid`=1, `ALU_result`=0x1234, WB=10 → next cycle `out_valid`=1, `out_ALU_result`=0x1234, `out_control_signal_WB`=10, `stall` never high.
- Load, ack on 3rd `WAIT` cycle: `ALU_result`=0x40, `dmem_rdata`=0xDEADBEEF → `stall` high 3 cycles, `dmem_addr`=0x40, `dmem_we`=0, then `out_MEM_read_data`=0xDEADBEEF, `out_valid`=1.
- Store then immediate load, ack=1 on first `WAIT` cycle for both: store data 0xA5A5A5A5 at 0x80, load 0x84 → each op stalls exactly 1 cycle; store output has `out_MEM_read_data`=0; no gap between the two requests beyond the `IDLE` cycle.
- Misaligned load 0x42, then `mem_read`=`mem_write`=1 at 0x50 → no `dmem_req`; `err_valid` pulses with codes 01 (addr 0x42) then 11 (addr 0x50); both outputs have WB=00.
- Timeout with `TIMEOUT`=4, ack never given → after 4 `WAIT` cycles `dmem_req`=0, `err_code`=10, `err_addr`=request address, `out_control_signal_WB`=00. Repeat with ack in the last cycle → normal completion, no error.
- Reset asserted mid-`WAIT` → `dmem_req`, `out_valid` and `stall` go to 0 immediately without a clock edge; after release the block is in `IDLE` and a new load completes normally.
